// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - SD command sequencer: descriptor in, serial-host handshakes, response check out.
// All outputs are registered; the comb process computes next values for every register.
module sd_cmd_sequencer #(
  parameter logic [2:0] DLY_CYCLES    = 3'd7,
  parameter logic [6:0] RSP_SHORT_LEN = 7'd40,
  parameter logic [6:0] RSP_LONG_LEN  = 7'd127
) (
  input  logic        SD_CLK_IN,
  input  logic        RST_IN,
  input  logic        new_cmd_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] argument_i,
  input  logic [1:0]  rsp_type_i,
  input  logic        crc_check_i,
  input  logic        idx_check_i,
  input  logic        blk_wr_i,
  input  logic        blk_rd_i,
  input  logic [1:0]  word_sel_i,
  input  logic [15:0] timeout_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  err_o,
  output logic [31:0] response_o,
  output logic [15:0] setting_o,
  output logic [39:0] cmd_o,
  output logic        req_o,
  input  logic        ack_i,
  input  logic        req_i,
  output logic        ack_o,
  input  logic [39:0] cmd_i,
  input  logic [7:0]  status_i,
  output logic        host_rst_o
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_TAKE, WAIT_EVT, ACK_EVT, WAIT_REL, CHECK, ABORT
  } state_t;

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [7:0]  status_q, status_n;
  logic        crc_chk_q, crc_chk_n, idx_chk_q, idx_chk_n;
  logic [1:0]  rsp_type_q, rsp_type_n;
  logic [5:0]  cmd_index_q, cmd_index_n;
  logic        busy_n, done_n, req_n, ack_n, host_rst_n;
  logic [3:0]  err_n;
  logic [31:0] response_n;
  logic [15:0] setting_n;
  logic [39:0] cmd_n;
  logic [6:0]  len;
  logic        rsp_expected;

  always_comb begin
    case (rsp_type_i)
      2'b01:   len = RSP_SHORT_LEN;
      2'b10:   len = RSP_LONG_LEN;
      default: len = 7'd0;
    endcase
  end

  assign rsp_expected = (rsp_type_q == 2'b01) || (rsp_type_q == 2'b10);

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    status_n    = status_q;
    crc_chk_n   = crc_chk_q;
    idx_chk_n   = idx_chk_q;
    rsp_type_n  = rsp_type_q;
    cmd_index_n = cmd_index_q;
    busy_n      = busy_o;
    done_n      = 1'b0;
    host_rst_n  = 1'b0;
    err_n       = err_o;
    response_n  = response_o;
    setting_n   = setting_o;
    cmd_n       = cmd_o;
    req_n       = req_o;
    ack_n       = ack_o;

    // A start while busy is dropped but remembered until the next accepted start.
    if (new_cmd_i && busy_o)
      err_n[3] = 1'b1;

    case (state)
      IDLE: begin
        if (new_cmd_i) begin
          crc_chk_n   = crc_check_i;
          idx_chk_n   = idx_check_i;
          rsp_type_n  = rsp_type_i;
          cmd_index_n = cmd_index_i;
          err_n       = 4'b0000;
          cmd_n       = {2'b01, cmd_index_i, argument_i};
          setting_n   = {1'b0, word_sel_i, blk_rd_i, blk_wr_i, DLY_CYCLES, crc_check_i, len};
          busy_n      = 1'b1;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        req_n   = 1'b1;
        state_n = WAIT_TAKE;
      end
      WAIT_TAKE: begin
        if (!ack_i) begin
          req_n   = 1'b0;
          timer_n = 16'd0;
          state_n = WAIT_EVT;
        end
      end
      WAIT_EVT: begin
        if (timer != 16'hFFFF)
          timer_n = timer + 16'd1;
        // An event in the timeout cycle takes priority over the timeout.
        if (req_i) begin
          status_n = status_i;
          ack_n    = 1'b1;
          state_n  = ACK_EVT;
        end else if (timeout_i != 16'd0 && timer == timeout_i - 16'd1) begin
          err_n[0] = 1'b1;
          state_n  = ABORT;
        end
      end
      ACK_EVT: begin
        if (!req_i) begin
          if (status_q[6]) begin
            state_n = WAIT_REL;
          end else begin
            ack_n   = 1'b0;
            state_n = WAIT_EVT;
          end
        end
      end
      WAIT_REL: begin
        if (ack_i) begin
          ack_n   = 1'b0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        response_n = cmd_i[31:0];
        err_n[1]   = crc_chk_q && !status_q[5] && rsp_expected;
        err_n[2]   = idx_chk_q && (rsp_type_q == 2'b01) && (cmd_i[37:32] != cmd_index_q);
        done_n     = 1'b1;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end
      ABORT: begin
        host_rst_n = 1'b1;
        req_n      = 1'b0;
        ack_n      = 1'b0;
        done_n     = 1'b1;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge SD_CLK_IN) begin
    if (RST_IN) begin
      state       <= IDLE;
      timer       <= 16'd0;
      status_q    <= 8'd0;
      crc_chk_q   <= 1'b0;
      idx_chk_q   <= 1'b0;
      rsp_type_q  <= 2'b00;
      cmd_index_q <= 6'd0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 4'b0000;
      response_o  <= 32'd0;
      setting_o   <= 16'd0;
      cmd_o       <= 40'd0;
      req_o       <= 1'b0;
      ack_o       <= 1'b0;
      host_rst_o  <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      status_q    <= status_n;
      crc_chk_q   <= crc_chk_n;
      idx_chk_q   <= idx_chk_n;
      rsp_type_q  <= rsp_type_n;
      cmd_index_q <= cmd_index_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      err_o       <= err_n;
      response_o  <= response_n;
      setting_o   <= setting_n;
      cmd_o       <= cmd_n;
      req_o       <= req_n;
      ack_o       <= ack_n;
      host_rst_o  <= host_rst_n;
    end
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Command-level controller that sequences the SD command serial host for the software-facing register block. It takes one command descriptor (index, argument, response type, check enables), builds the 40-bit command word and 16-bit setting word, and runs the request/acknowledge handshakes with the serial host. It tracks the serial host's status events, enforces a response timeout, checks the response, and reports completion, error flags and the 32-bit response field.

Parameters:
DLY_CYCLES, 3'd7, value driven on setting_o[10:8] (post-write delay for no-response commands)
RSP_SHORT_LEN, 7'd40, setting_o[6:0] for 48-bit responses
RSP_LONG_LEN, 7'd127, setting_o[6:0] for 136-bit responses

Ports:
SD_CLK_IN  in  1  clock (SD clock domain)
RST_IN  in  1  reset, synchronous, active-high
new_cmd_i  in  1  one-cycle start pulse
cmd_index_i  in  6  command index
argument_i  in  32  command argument
rsp_type_i  in  2  00 none, 01 48-bit, 10 136-bit, 11 reserved (treated as none)
crc_check_i  in  1  enable CRC check
idx_check_i  in  1  enable response index check
blk_wr_i  in  1  forwarded to setting_o[11]
blk_rd_i  in  1  forwarded to setting_o[12]
word_sel_i  in  2  forwarded to setting_o[14:13]
timeout_i  in  16  response timeout in SD_CLK_IN cycles; 0 disables timeout
busy_o  out  1  command in progress
done_o  out  1  one-cycle completion pulse
err_o  out  4  [0] timeout, [1] CRC, [2] index, [3] rejected start
response_o  out  32  response bits cmd_i[31:0]
setting_o  out  16  to serial host SETTING_IN
cmd_o  out  40  to serial host CMD_IN
req_o  out  1  to serial host REQ_IN
ack_i  in  1  from serial host ACK_OUT
req_i  in  1  from serial host REQ_OUT
ack_o  out  1  to serial host ACK_IN
cmd_i  in  40  from serial host CMD_OUT
status_i  in  8  from serial host STATUS
host_rst_o  out  1  reset pulse to serial host

Behaviour:
- Reset: state IDLE; all outputs 0 except none; timer 0. Reset mid-command aborts silently, no done_o.
- States: IDLE, ISSUE, WAIT_TAKE, WAIT_EVT, ACK_EVT, WAIT_REL, CHECK, ABORT.
- IDLE: on new_cmd_i, latch the descriptor, clear err_o, and drive the outputs below. cmd_o = {2'b01, cmd_index_i, argument_i}. setting_o = {1'b0, word_sel_i, blk_rd_i, blk_wr_i, DLY_CYCLES, crc_check_i, len}. len is 0, RSP_SHORT_LEN or RSP_LONG_LEN per rsp_type_i. Set busy_o=1 and go to ISSUE in the same edge.
- new_cmd_i while busy_o=1: ignored; err_o[3] set (sticky until next accepted start).
- ISSUE: req_o=1, then WAIT_TAKE.
- WAIT_TAKE: hold req_o=1 until ack_i=0 is sampled. Then clear req_o, zero the timer, and go to WAIT_EVT.
- WAIT_EVT: the timer increments every cycle, saturating at 16'hFFFF.
  - On req_i=1: capture status_i, set ack_o=1, go to ACK_EVT.
  - Else, if timeout_i!=0 and timer==timeout_i-1: set err_o[0] and go to ABORT.
  - An event that arrives in the same cycle as the timeout wins; no timeout is flagged.
- ACK_EVT: hold ack_o=1 until req_i=0 is sampled.
  - If captured status[6]=0 (intermediate event, codes 1/2/3/5): clear ack_o and return to WAIT_EVT. The timer is not reset.
  - If status[6]=1 (final, code 4 or 6): keep ack_o=1 and go to WAIT_REL.
- WAIT_REL: ack_o=1 until ack_i=1 is sampled, then ack_o=0 and go to CHECK.
- CHECK (one cycle):
  - response_o=cmd_i[31:0].
  - err_o[1] = crc_check & (captured status[5]==0) & response expected.
  - err_o[2] = idx_check & rsp_type==01 & (cmd_i[37:32]!=cmd_index).
  - done_o=1, busy_o=0 next cycle, go to IDLE.
- ABORT (one cycle): host_rst_o=1, req_o=0, ack_o=0, done_o=1, then IDLE with busy_o=0.
- No-response commands still wait for the code-4 final event. Timeout applies to them too.
- done_o is never asserted for a rejected start.

Test Plan:
- CMD0 (idx 0, arg 0, rsp none) with serial-host model → cmd_o=40'h40_0000_0000, setting_o[6:0]=0, [10:8]=7. Events 2 then 4 acked. done_o one pulse, err_o=0.
- CMD17 arg 32'h0000_0200, rsp 48-bit, blk_rd_i=1. Model returns status 6 with bit5=1 and cmd_i[37:32]=17, cmd_i[31:0]=32'h0000_0900 → setting_o[6:0]=40, bit12=1, response_o=32'h0000_0900, err_o=0.
- Same as above but status bit5=0 with crc_check_i=1 → err_o=4'b0010. Repeat with crc_check_i=0 → err_o=0.
- rsp 48-bit, cmd_i[37:32]=5 vs index 8, idx_check_i=1 → err_o[2]=1, done_o pulse.
- timeout_i=16'd100, model never raises the final event → after 100 cycles in WAIT_EVT: err_o=4'b0001, host_rst_o one-cycle pulse, done_o pulse, IDLE.
- new_cmd_i pulsed mid-command → err_o[3]=1, cmd_o unchanged. Also: RST_IN asserted during WAIT_EVT → all outputs 0 on the next edge, no done_o.
